// File: rtl/irq_ctrl.sv
// Interrupt controller: samples source lines, latches edge/level pending bits,
// masks them onto HWInt and exposes PEND/MASK/MODE/STAT as four bridge words.
module irq_ctrl #(
    parameter int unsigned        N_SRC        = 6,
    parameter logic [N_SRC-1:0]   EDGE_DEFAULT = 6'b000100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic [N_SRC-1:0] hwint,
    output logic             irq_any
);

    logic [N_SRC-1:0] r_samp;
    logic [N_SRC-1:0] r_prev;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_mode;
    logic [N_SRC-1:0] r_ovf;

    logic [N_SRC-1:0] w_din;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_pend_d;
    logic [N_SRC-1:0] w_ovf_d;
    logic [2:0]       w_idx;
    logic [7:0]       w_ovf_ext;
    logic             w_unused_din;

    assign w_din        = din[N_SRC-1:0];
    assign w_unused_din = ^din[31:N_SRC];

    assign w_rise = r_samp & ~r_prev;
    assign w_clr  = (we && addr == 2'd0) ? w_din : '0;

    // Edge sources: a new rise beats a same-cycle W1C. Level sources follow samp.
    assign w_pend_d = (r_mode & ((r_pend & ~w_clr) | w_rise)) | (~r_mode & r_samp);
    assign w_ovf_d  = (r_ovf & ~w_clr) | (r_mode & w_rise & r_pend);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_samp <= '0;
            r_prev <= '0;
            r_pend <= '0;
            r_mask <= '0;
            r_mode <= EDGE_DEFAULT;
            r_ovf  <= '0;
        end else begin
            r_samp <= irq_in;
            r_prev <= r_samp;
            r_pend <= w_pend_d;
            r_ovf  <= w_ovf_d;
            if (we && addr == 2'd1) begin
                r_mask <= w_din;
            end
            if (we && addr == 2'd2) begin
                r_mode <= w_din;
            end
        end
    end

    assign hwint   = r_pend & r_mask;
    assign irq_any = |hwint;

    // Lowest-numbered active line has the highest priority.
    always_comb begin
        w_idx = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (hwint[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    assign w_ovf_ext = 8'(r_ovf);

    always_comb begin
        dout = '0;
        unique case (addr)
            2'd0: dout = 32'(r_pend);
            2'd1: dout = 32'(r_mask);
            2'd2: dout = 32'(r_mode);
            2'd3: dout = {irq_any, 15'b0, w_ovf_ext, 5'b0, w_idx};
            default: dout = '0;
        endcase
    end

endmodule
